// File: rtl/serial_comparator32.sv
// Bit-serial magnitude comparator: MSB-first, early exit on the first differing bit.
// Optional two's-complement mode when SERIAL_CMP_SIGNED_EN is defined (adds port signed_mode).
module serial_comparator32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             gr,
    output logic             lt,
    output logic             eq
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [CW-1:0]    cnt_q;
    logic             sgn_q;
    logic             sgn_in;
    logic             msb_a;
    logic             msb_b;
    logic             first_bit;

`ifdef SERIAL_CMP_SIGNED_EN
    assign sgn_in = signed_mode;
`else
    assign sgn_in = 1'b0;
`endif

    assign busy      = (state_q == StRun);
    assign msb_a     = sh_a_q[WIDTH-1];
    assign msb_b     = sh_b_q[WIDTH-1];
    // The counter still holds its load value only while the sign bit is under test.
    assign first_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            done    <= 1'b0;
            gr      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                state_q <= StIdle;
                gr      <= 1'b0;
                lt      <= 1'b0;
                eq      <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            sh_a_q  <= a;
                            sh_b_q  <= b;
                            sgn_q   <= sgn_in;
                            cnt_q   <= CW'(WIDTH - 1);
                            gr      <= 1'b0;
                            lt      <= 1'b0;
                            eq      <= 1'b0;
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        if (msb_a != msb_b) begin
                            // Two's complement: a set sign bit means the smaller operand.
                            if (sgn_q && first_bit) begin
                                gr <= msb_b;
                                lt <= msb_a;
                            end else begin
                                gr <= msb_a;
                                lt <= msb_b;
                            end
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end else if (cnt_q != '0) begin
                            sh_a_q <= {sh_a_q[WIDTH-2:0], 1'b0};
                            sh_b_q <= {sh_b_q[WIDTH-2:0], 1'b0};
                            cnt_q  <= cnt_q - 1'b1;
                        end else begin
                            eq      <= 1'b1;
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_comparator32.sv
// Self-checking bench for serial_comparator32: directed corner cases plus randomized
// operands checked against an arithmetic reference model.
module tb_serial_comparator32;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         clr   = 1'b0;
    logic         sm    = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, gr, lt, eq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_comparator32 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clr        (clr),
        .a          (a),
        .b          (b),
`ifdef SERIAL_CMP_SIGNED_EN
        .signed_mode(sm),
`endif
        .busy       (busy),
        .done       (done),
        .gr         (gr),
        .lt         (lt),
        .eq         (eq)
    );

    // Reference: relation from plain arithmetic, latency from the highest differing bit.
    task automatic ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           output logic [2:0] res, output int lat);
        logic [W-1:0] d;
        logic eg, ee;
        d  = x ^ y;
        ee = (x == y);
        if (s) eg = ($signed(x) > $signed(y));
        else   eg = (x > y);
        res = {eg, !ee && !eg, ee};
        lat = W;
        for (int i = 0; i < W; i++) if (d[i]) lat = W - i;
    endtask

    // Drive a start; returns #1 after the accept edge with operands scrambled.
    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        a = x; b = y; sm = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sm = $urandom_range(0, 1);
    endtask

    // Edges until done is seen; -1 if the budget expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= W + 8; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, gr, lt, eq} !== 5'b0) begin
            failures++;
            $display("FAIL reset_active: got %b want 00000", {busy, done, gr, lt, eq});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, gr, lt, eq} !== 5'b0) begin
            failures++;
            $display("FAIL reset_release: got %b want 00000", {busy, done, gr, lt, eq});
        end
    endtask

    task automatic test_directed();
        int lat;
        do_start(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 1 || {gr, lt, eq} !== 3'b100) begin
            failures++;
            $display("FAIL msb_gr: lat=%0d gle=%b want lat=1 gle=100", lat, {gr, lt, eq});
        end
        do_start(32'h1234_5678, 32'h1234_5678, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 32 || {gr, lt, eq} !== 3'b001) begin
            failures++;
            $display("FAIL equal: lat=%0d gle=%b want lat=32 gle=001", lat, {gr, lt, eq});
        end
        do_start(32'h0000_0000, 32'h0000_0001, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 32 || {gr, lt, eq} !== 3'b010) begin
            failures++;
            $display("FAIL lsb_lt: lat=%0d gle=%b want lat=32 gle=010", lat, {gr, lt, eq});
        end
`ifdef SERIAL_CMP_SIGNED_EN
        do_start(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 1 || {gr, lt, eq} !== 3'b010) begin
            failures++;
            $display("FAIL signed_msb: lat=%0d gle=%b want lat=1 gle=010", lat, {gr, lt, eq});
        end
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 32 || {gr, lt, eq} !== 3'b100) begin
            failures++;
            $display("FAIL signed_lsb: lat=%0d gle=%b want lat=32 gle=100", lat, {gr, lt, eq});
        end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic [2:0]   res;
        logic         s;
        int           lat, elat, k;
        for (int n = 0; n < 40; n++) begin
            x = $urandom;
            k = $urandom_range(0, W - 1);
            case ($urandom_range(0, 3))
                0:       y = $urandom;
                1:       y = x;
                2:       y = x ^ (32'd1 << k);
                default: y = x ^ (32'hFFFF_FFFF >> k);
            endcase
`ifdef SERIAL_CMP_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            ref_cmp(x, y, s, res, elat);
            do_start(x, y, s);
            wait_done(lat);
            checks++;
            if (lat !== elat || {gr, lt, eq} !== res) begin
                failures++;
                $display("FAIL random a=%h b=%h s=%b: lat=%0d gle=%b want lat=%0d gle=%b",
                         x, y, s, lat, {gr, lt, eq}, elat, res);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || {gr, lt, eq} !== res) begin
                failures++;
                $display("FAIL hold a=%h b=%h: done=%b busy=%b gle=%b want done=0 busy=0 gle=%b",
                         x, y, done, busy, {gr, lt, eq}, res);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y;
        logic [2:0]   res;
        int           lat, elat;
        x = $urandom;
        do_start(x, x, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        a = x ^ 32'h8000_0000; b = x; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        checks++;
        if (lat < 0 || lat + 5 !== 32 || {gr, lt, eq} !== 3'b001) begin
            failures++;
            $display("FAIL busy_start: lat=%0d gle=%b want lat=32 gle=001", lat + 5, {gr, lt, eq});
        end
        x = $urandom;
        y = x ^ (32'd1 << $urandom_range(0, W - 1));
        ref_cmp(x, y, 1'b0, res, elat);
        a = x; b = y; sm = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~x; b = ~y;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(lat);
        checks++;
        if (lat !== elat || {gr, lt, eq} !== res) begin
            failures++;
            $display("FAIL b2b_result: lat=%0d gle=%b want lat=%0d gle=%b",
                     lat, {gr, lt, eq}, elat, res);
        end
    endtask

    task automatic test_clr();
        int lat, ndone;
        do_start(32'd2, 32'd1, 1'b0);
        wait_done(lat);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if ({busy, done, gr, lt, eq} !== 5'b0) begin
            failures++;
            $display("FAIL clr_idle: got %b want 00000", {busy, done, gr, lt, eq});
        end
        do_start(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if ({busy, done, gr, lt, eq} !== 5'b0) begin
            failures++;
            $display("FAIL clr_run: got %b want 00000", {busy, done, gr, lt, eq});
        end
        ndone = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL clr_no_done: done pulses=%0d want 0", ndone);
        end
        a = 32'd5; b = 32'd3; clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL clr_start: busy=%b done=%b want busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] res;
        int         lat, elat, ndone;
        do_start(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, gr, lt, eq} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset: got %b want 00000", {busy, done, gr, lt, eq});
        end
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL reset_no_done: active cycles=%0d want 0", ndone);
        end
        ref_cmp(32'd5, 32'd3, 1'b0, res, elat);
        do_start(32'd5, 32'd3, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== elat || {gr, lt, eq} !== res) begin
            failures++;
            $display("FAIL first_after_reset: lat=%0d gle=%b want lat=%0d gle=%b",
                     lat, {gr, lt, eq}, elat, res);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_comparator32.md
SERIAL_COMPARATOR32 -- requirements
Module: serial_comparator32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to compare a and b, sampled only when busy=0.
REQ-005 SHALL have port clr  input  1  synchronous abort, returns the block to IDLE.
REQ-006 SHALL have port a  input  WIDTH  operand A, sampled on the start-accept edge.
REQ-007 SHALL have port b  input  WIDTH  operand B, sampled on the start-accept edge.
REQ-008 SHALL have port busy  output  1  high while a comparison is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have ports gr, lt, eq  output  1 each  A>B, A<B, A==B; these are one-hot once a result is present.

Function
REQ-011 SHALL implement states IDLE and RUN; busy=1 exactly in RUN.
REQ-012 In IDLE, start=1 and clr=0 at a rising edge SHALL capture a and b into internal shift registers, clear gr/lt/eq, load bit counter to WIDTH-1 and enter RUN.
REQ-013 In RUN, each edge SHALL compare the MSBs of the A and B shift registers, processing operand bit WIDTH-1 first and bit 0 last.
REQ-014 If the compared bits differ, the block SHALL set gr (A bit 1) or lt (B bit 1), pulse done and return to IDLE on that edge (early exit).
REQ-015 If the bits are equal and the counter is nonzero, the block SHALL shift both registers left by one and decrement the counter.
REQ-016 If the bits are equal and the counter is 0, the block SHALL set eq, pulse done and return to IDLE.
REQ-017 Latency SHALL be k+1 clocks from the start-accept edge to done high, where k is the number of leading equal bits, capped at WIDTH-1; the maximum latency is WIDTH clocks.
REQ-018 done SHALL be high for exactly one cycle per completed comparison.
REQ-019 gr/lt/eq SHALL hold their value until the next accepted start, clr or reset.
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the result.
REQ-021 start sampled in the cycle where done=1 SHALL be accepted, allowing back-to-back operation with no idle cycle.
REQ-022 clr=1 SHALL force IDLE and clear gr/lt/eq/done on the next edge, with no done pulse.
REQ-023 When clr and start are high on the same edge, clr SHALL win and start SHALL be dropped.
REQ-024 Changes to a and b after the start-accept edge SHALL NOT affect the result.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE and set busy=0, done=0, gr=0, lt=0, eq=0, counter=0 and both shift registers to 0.
REQ-026 Reset asserted mid-RUN SHALL abort the comparison with no done pulse.
REQ-027 The first start after rst_n deassertion SHALL be accepted normally.

Configuration
REQ-028 Macro SERIAL_CMP_SIGNED_EN defined SHALL add port signed_mode  input  1, sampled on the start-accept edge.
REQ-029 With signed_mode=1, a mismatch at operand bit WIDTH-1 SHALL set lt when A's bit is 1 and gr when B's bit is 1 (two's complement); all other bits behave as unsigned.
REQ-030 With SERIAL_CMP_SIGNED_EN undefined, the signed_mode port SHALL be absent and all comparisons SHALL be unsigned.

Verification
REQ-031 SHALL cover: a=0x80000000, b=0x7FFFFFFF, unsigned -> done 1 clock after accept, gr=1, lt=0, eq=0.
REQ-032 SHALL cover: a=b=0x12345678 -> done 32 clocks after accept, eq=1; a=0x00000000, b=0x00000001 -> done at 32 clocks, lt=1.
REQ-033 SHALL cover: with SERIAL_CMP_SIGNED_EN, signed_mode=1, a=0x80000000, b=0x7FFFFFFF -> done at 1 clock, lt=1; a=0xFFFFFFFF, b=0xFFFFFFFE -> done at 32 clocks, gr=1.
REQ-034 SHALL cover: start pulsed at clock 5 of a running equal-operand compare -> ignored, single done at 32 clocks, eq=1; start held in the done cycle -> second compare accepted immediately.
REQ-035 SHALL cover: clr at clock 10 of a run -> busy=0 next edge, no done, gr=lt=eq=0; clr and start together in IDLE -> remains IDLE.
REQ-036 SHALL cover: rst_n low asynchronously mid-run (between edges) -> all outputs 0 immediately, no done after release.
